// File: rtl/wb_pkg.sv
// Shared definitions for the writeback arbiter: source encoding, lane width
// and the packed width of one buffered load-return entry.
package wb_pkg;

    // Which stream owns the register-bank write port in a given cycle
    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MEM = 1'b1
    } wb_src_e;

    // Bits per lane; lane i lives at [i*WB_DATA_WIDTH +: WB_DATA_WIDTH]
    localparam int unsigned WB_DATA_WIDTH = 32;

    // One FIFO entry is {waddr, mask, wdata}
    function automatic int unsigned wb_entry_width(input int unsigned log2_num_regs,
                                                   input int unsigned num_lanes,
                                                   input int unsigned data_width);
        return log2_num_regs + num_lanes + num_lanes * data_width;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Parameterised synchronous FIFO with occupancy count. Pointers wrap modulo
// DEPTH (power of 2); a separate count register disambiguates full/empty.
module wb_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rptr_q];

    // Overflow/underflow cannot corrupt state even if the caller misbehaves
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy next-state: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges the ALU writeback stream and the buffered load-return stream onto
// the single per-lane register-bank write port. ALU has priority; a load
// that has lost STARVE_LIMIT consecutive cycles, or a full FIFO, forces the
// load through. The write port is registered: one cycle from grant to write.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_LANES     = 8,
    parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int unsigned LOG2_NUM_REGS = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned STARVE_LIMIT  = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [LOG2_NUM_REGS-1:0]          alu_waddr,
    input  logic [NUM_LANES-1:0]              alu_mask,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   alu_wdata,
    input  logic                              mem_valid,
    output logic                              mem_ready,
    input  logic [LOG2_NUM_REGS-1:0]          mem_waddr,
    input  logic [NUM_LANES-1:0]              mem_mask,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   mem_wdata,
    output logic [NUM_LANES-1:0]              rf_write_en,
    output logic [LOG2_NUM_REGS-1:0]          rf_waddr,
    output logic [NUM_LANES*DATA_WIDTH-1:0]   rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);
    localparam int unsigned ENTRY_W  = wb_entry_width(LOG2_NUM_REGS, NUM_LANES, DATA_WIDTH);
    localparam int unsigned BUS_W    = NUM_LANES * DATA_WIDTH;
    localparam int unsigned STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [ENTRY_W-1:0]       fifo_head;
    logic [LOG2_NUM_REGS-1:0] head_waddr;
    logic [NUM_LANES-1:0]     head_mask;
    logic [BUS_W-1:0]         head_wdata;

    logic                     mem_sel;
    wb_src_e                  src;
    logic [STARVE_W-1:0]      starve_q;
    logic [STARVE_W-1:0]      starve_d;

    logic [NUM_LANES-1:0]     rf_write_en_q, rf_write_en_d;
    logic [LOG2_NUM_REGS-1:0] rf_waddr_q, rf_waddr_d;
    logic [BUS_W-1:0]         rf_wdata_q, rf_wdata_d;

    // Every load goes through the FIFO; mem_ready depends on registered count only
    assign mem_ready = !fifo_full;
    assign fifo_push = mem_valid && mem_ready;
    assign fifo_pop  = mem_sel;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_load_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({mem_waddr, mem_mask, mem_wdata}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {head_waddr, head_mask, head_wdata} = fifo_head;

    // Load wins when the ALU is idle, the FIFO is full, or the load has starved
    always_comb begin
        mem_sel   = !fifo_empty && (!alu_valid || fifo_full || (starve_q == STARVE_MAX));
        alu_ready = !mem_sel;
        src       = mem_sel ? WB_SRC_MEM : WB_SRC_ALU;
    end

    // Count consecutive losses of a non-empty FIFO, saturating at the limit
    always_comb begin
        starve_d = starve_q;
        if (mem_sel || fifo_empty) begin
            starve_d = '0;
        end else if (alu_valid && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Write-port next state; address and data hold when nothing is granted
    always_comb begin
        rf_write_en_d = '0;
        rf_waddr_d    = rf_waddr_q;
        rf_wdata_d    = rf_wdata_q;
        if (mem_sel || alu_valid) begin
            unique case (src)
                WB_SRC_MEM: begin
                    rf_write_en_d = head_mask;
                    rf_waddr_d    = head_waddr;
                    rf_wdata_d    = head_wdata;
                end
                WB_SRC_ALU: begin
                    rf_write_en_d = alu_mask;
                    rf_waddr_d    = alu_waddr;
                    rf_wdata_d    = alu_wdata;
                end
            endcase
        end
    end

    // Starvation counter and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q      <= '0;
            rf_write_en_q <= '0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
        end else begin
            starve_q      <= starve_d;
            rf_write_en_q <= rf_write_en_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
        end
    end

    assign rf_write_en = rf_write_en_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: a queue-based model of the arbiter
// is checked every cycle, and directed scenarios pin literal expectations.
module tb_writeback_arbiter;
    localparam int NL = 8;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int FD = 4;
    localparam int SL = 3;
    localparam int BW = NL * DW;

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [NL-1:0] mask;
        logic [BW-1:0] wdata;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [AW-1:0] alu_waddr = '0;
    logic [NL-1:0] alu_mask = '0;
    logic [BW-1:0] alu_wdata = '0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [AW-1:0] mem_waddr = '0;
    logic [NL-1:0] mem_mask = '0;
    logic [BW-1:0] mem_wdata = '0;
    logic [NL-1:0] rf_write_en;
    logic [AW-1:0] rf_waddr;
    logic [BW-1:0] rf_wdata;
    logic [2:0]    fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    ent_t          m_q[$];
    int            m_starve = 0;
    logic [NL-1:0] m_en = '0;
    logic [AW-1:0] m_addr = '0;
    logic [BW-1:0] m_data = '0;
    logic          m_nonempty, m_full, m_sel, m_push;
    ent_t          m_head;

    writeback_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_waddr   (alu_waddr),
        .alu_mask    (alu_mask),
        .alu_wdata   (alu_wdata),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_waddr   (mem_waddr),
        .mem_mask    (mem_mask),
        .mem_wdata   (mem_wdata),
        .rf_write_en (rf_write_en),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] mk_data(input logic [31:0] lane0);
        logic [BW-1:0] d;
        for (int i = 0; i < NL; i++) d[i*DW +: DW] = lane0 + 32'(i) * 32'h0101_0000;
        return d;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [AW-1:0] a, input logic [NL-1:0] m,
                           input logic [31:0] d0);
        alu_valid = v;
        alu_waddr = a;
        alu_mask  = m;
        alu_wdata = mk_data(d0);
    endtask

    task automatic set_mem(input logic v, input logic [AW-1:0] a, input logic [NL-1:0] m,
                           input logic [31:0] d0);
        mem_valid = v;
        mem_waddr = a;
        mem_mask  = m;
        mem_wdata = mk_data(d0);
    endtask

    // Model: arbitration rules applied to a queue of pending loads
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_starve = 0;
            m_en     = '0;
            m_addr   = '0;
            m_data   = '0;
        end else begin
            m_nonempty = (m_q.size() != 0);
            m_full     = (m_q.size() == FD);
            m_sel      = m_nonempty && (!alu_valid || m_full || m_starve == SL);
            m_push     = mem_valid && !m_full;
            if (m_sel) begin
                m_head = m_q.pop_front();
                m_en   = m_head.mask;
                m_addr = m_head.waddr;
                m_data = m_head.wdata;
            end else if (alu_valid) begin
                m_en   = alu_mask;
                m_addr = alu_waddr;
                m_data = alu_wdata;
            end else begin
                m_en = '0;
            end
            if (m_sel || !m_nonempty) m_starve = 0;
            else if (alu_valid && m_starve < SL) m_starve++;
            if (m_push) m_q.push_back('{waddr: mem_waddr, mask: mem_mask, wdata: mem_wdata});
        end
    end

    // Compare DUT against model every cycle, mid-low-phase
    initial forever begin
        @(negedge clk);
        #3;
        check("alu_ready", alu_ready,
              !((m_q.size() != 0) && (!alu_valid || m_q.size() == FD || m_starve == SL)));
        check("mem_ready", mem_ready, m_q.size() != FD);
        check("fifo_count", fifo_count, m_q.size());
        check("rf_write_en", rf_write_en, m_en);
        check("rf_waddr", rf_waddr, m_addr);
        check("rf_wdata", rf_wdata, m_data);
    end

    initial begin
        #1 rst = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();
        check("reset_en", rf_write_en, 0);
        check("reset_waddr", rf_waddr, 0);
        check("reset_wdata", rf_wdata, 0);
        check("reset_count", fifo_count, 0);

        // ALU only
        set_alu(1, 4'd5, 8'hFF, 32'h1234);
        #1 check("alu_only_ready", alu_ready, 1);
        next_cycle();
        check("alu_only_en", rf_write_en, 8'hFF);
        check("alu_only_waddr", rf_waddr, 5);
        check("alu_only_lane0", rf_wdata[31:0], 32'h1234);
        set_alu(0, 4'd0, 8'h00, 32'h0);
        next_cycle();
        check("idle_en", rf_write_en, 0);
        check("idle_hold_waddr", rf_waddr, 5);

        // Load only: visible two cycles after the push
        set_mem(1, 4'd9, 8'h0F, 32'hA000);
        #1 check("load_only_mem_ready", mem_ready, 1);
        next_cycle();
        set_mem(0, 4'd0, 8'h00, 32'h0);
        check("load_only_count1", fifo_count, 1);
        check("load_only_en_early", rf_write_en, 0);
        next_cycle();
        check("load_only_count0", fifo_count, 0);
        check("load_only_en", rf_write_en, 8'h0F);
        check("load_only_waddr", rf_waddr, 9);

        // Starvation guard
        set_alu(1, 4'd7, 8'h55, 32'hB000);
        set_mem(1, 4'd3, 8'hAA, 32'hC000);
        next_cycle();
        set_mem(0, 4'd0, 8'h00, 32'h0);
        check("starve_ready_c1", alu_ready, 1);
        next_cycle();
        check("starve_ready_c2", alu_ready, 1);
        next_cycle();
        check("starve_ready_c3", alu_ready, 1);
        next_cycle();
        check("starve_ready_c4", alu_ready, 0);
        next_cycle();
        check("starve_load_waddr", rf_waddr, 3);
        check("starve_load_en", rf_write_en, 8'hAA);
        check("starve_count", fifo_count, 0);
        check("starve_ready_after", alu_ready, 1);
        next_cycle();
        check("starve_alu_resume", rf_waddr, 7);
        set_alu(0, 4'd0, 8'h00, 32'h0);

        // Full FIFO with ALU busy, drain in push order
        set_alu(1, 4'd8, 8'hF0, 32'hD000);
        for (int i = 1; i <= 4; i++) begin
            set_mem(1, 4'(i), 8'(i), 32'hE000 + 32'(i));
            next_cycle();
        end
        check("full_count", fifo_count, 4);
        check("full_mem_ready", mem_ready, 0);
        check("full_forced_sel", alu_ready, 0);
        set_mem(1, 4'd15, 8'hFF, 32'hF000);
        next_cycle();
        check("drain_waddr1", rf_waddr, 1);
        check("drain_count3", fifo_count, 3);
        set_alu(0, 4'd0, 8'h00, 32'h0);
        set_mem(0, 4'd0, 8'h00, 32'h0);
        for (int i = 2; i <= 4; i++) begin
            next_cycle();
            check("drain_waddr", rf_waddr, i);
        end
        check("drain_count0", fifo_count, 0);

        // Zero mask consumes a slot without enabling lanes
        set_alu(1, 4'd6, 8'h00, 32'h6000);
        next_cycle();
        check("zero_mask_en", rf_write_en, 0);
        check("zero_mask_waddr", rf_waddr, 6);

        // Push and pop in the same cycle at count 2
        set_alu(1, 4'd13, 8'h3C, 32'h7000);
        set_mem(1, 4'd10, 8'h01, 32'h8000);
        next_cycle();
        set_mem(1, 4'd11, 8'h02, 32'h8100);
        next_cycle();
        check("pp_count_before", fifo_count, 2);
        set_alu(0, 4'd0, 8'h00, 32'h0);
        set_mem(1, 4'd12, 8'h04, 32'h8200);
        #1 check("pp_pop_granted", alu_ready, 0);
        next_cycle();
        check("pp_count_after", fifo_count, 2);
        check("pp_waddr_a", rf_waddr, 10);
        set_mem(0, 4'd0, 8'h00, 32'h0);
        next_cycle();
        check("pp_waddr_b", rf_waddr, 11);
        next_cycle();
        check("pp_waddr_c", rf_waddr, 12);
        check("pp_count_end", fifo_count, 0);

        // Reset mid-stream discards buffered loads
        set_alu(1, 4'd2, 8'h01, 32'h9000);
        for (int i = 0; i < 3; i++) begin
            set_mem(1, 4'(20 + i), 8'h80, 32'h9100 + 32'(i));
            next_cycle();
        end
        check("mid_count3", fifo_count, 3);
        set_alu(0, 4'd0, 8'h00, 32'h0);
        set_mem(0, 4'd0, 8'h00, 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_en", rf_write_en, 0);
        check("mid_rst_mem_ready", mem_ready, 1);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            check("post_rst_en", rf_write_en, 0);
            check("post_rst_count", fifo_count, 0);
        end

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Merges two writeback streams into the single write port of the per-lane register bank:
  - the ALU result stream;
  - the memory load-return stream.
- Load returns are buffered in a small FIFO.
- ALU has priority, with a starvation guard for loads.
- Drives per-lane write enables, write address and per-lane write data one cycle after a request is accepted.

Parameters:
- NUM_LANES, 8, number of SIMD lanes.
- DATA_WIDTH, 32, bits per lane.
- LOG2_NUM_REGS, 4, register address width.
- FIFO_DEPTH, 4, load-return FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose before it is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid && alu_ready.
- alu_waddr  in  LOG2_NUM_REGS  destination register.
- alu_mask  in  NUM_LANES  active-lane mask.
- alu_wdata  in  NUM_LANES*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- mem_valid  in  1  load-return request.
- mem_ready  out  1  FIFO can accept.
- mem_waddr  in  LOG2_NUM_REGS  destination register.
- mem_mask  in  NUM_LANES  active-lane mask.
- mem_wdata  in  NUM_LANES*DATA_WIDTH  same packing as alu_wdata.
- rf_write_en  out  NUM_LANES  per-lane write enable to register bank.
- rf_waddr  out  LOG2_NUM_REGS  write address.
- rf_wdata  out  NUM_LANES*DATA_WIDTH  per-lane write data.
- fifo_count  out  LOG2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release) clears:
  - rf_write_en = 0, rf_waddr = 0, rf_wdata = 0;
  - FIFO pointers and count = 0;
  - starve_cnt = 0.
- Reset mid-operation discards all buffered loads; no partial write is issued.
- mem_ready = (fifo_count != FIFO_DEPTH), from registered state only.
- Load push = mem_valid && mem_ready. A load always enters the FIFO; there is no bypass. Minimum load-to-write latency is 2 cycles.
- Arbitration (combinational on registered state):
  - mem_sel = fifo_nonempty && (!alu_valid || fifo_full || starve_cnt == STARVE_LIMIT).
  - alu_ready = !mem_sel.
  - Pop = mem_sel.
- Push and pop in the same cycle: both occur and the count is unchanged.
  - Push while full is impossible (mem_ready = 0).
  - Pop while empty is impossible (gated by fifo_nonempty).
- starve_cnt rules:
  - Increments when fifo_nonempty && alu_valid && !mem_sel.
  - Clears when mem_sel or the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Output register, 1-cycle latency from grant:
  - ALU grant: rf_write_en <= alu_mask, rf_waddr <= alu_waddr, rf_wdata <= alu_wdata.
  - FIFO grant: the same three outputs load from the FIFO head entry.
  - No grant: rf_write_en <= 0, and rf_waddr / rf_wdata hold their previous values.
- A mask of 0 is accepted and consumes a slot, but produces rf_write_en = 0.
- Write bandwidth is one request per cycle; there are no stalls from the register bank.
- The FIFO stores {waddr, mask, wdata}. Pointers wrap modulo FIFO_DEPTH, with a separate count register.
- Ordering:
  - Load order is preserved.
  - ALU-vs-load order is not guaranteed; same-register hazards are the scoreboard's responsibility.

Decomposition:
- Shared package wb_pkg:
  - WB_SRC_ALU / WB_SRC_MEM encodings;
  - lane-slice helper constant DATA_WIDTH;
  - the FIFO entry width expression (LOG2_NUM_REGS + NUM_LANES + NUM_LANES*DATA_WIDTH).
- One sub-module: wb_fifo.
  - Parameterised synchronous FIFO: push/pop, full/empty, count; asynchronous active-high reset.
  - Instantiated once for the load path.
- Arbitration, starvation counter and output register stay in the top module.

Test Plan:
- Reset mid-stream: push 3 loads, assert rst for 1 cycle → fifo_count = 0, rf_write_en = 0, no writes after release.
- ALU only: alu_valid = 1, waddr = 5, mask = 8'hFF, lane0 data 32'h1234 → alu_ready = 1; next cycle rf_write_en = 8'hFF, rf_waddr = 5, rf_wdata[31:0] = 32'h1234.
- Load only: single mem push, waddr = 9, mask = 8'h0F → mem_ready = 1; rf_write_en = 8'h0F, rf_waddr = 9 two cycles after push; fifo_count goes 1 then 0.
- Starvation guard: one load buffered while alu_valid is held high → ALU wins 3 cycles, load wins on the 4th (alu_ready = 0 that cycle), ALU resumes after.
- Full FIFO: push 4 loads while the ALU is held busy → mem_ready = 0 at count 4, mem_sel forced, and the loads drain in push order (waddr 1, 2, 3, 4).
- Zero mask plus simultaneous push/pop: one ALU request with mask 0 → rf_write_en stays 0. Then, with FIFO count 2 and the pop granted, push a new load in the same cycle → fifo_count remains 2.
